tdm_demux1_to_4: RTL and testbench

- Receive-side counterpart of the 4-to-1 channel mux.
- Takes one time-division-multiplexed stream carrying four channels in fixed slot order i0, i1, i2, i3, marked by a frame sync.
- Steers each slot to its own channel register and presents all four channels together, one frame at a time, with a valid strobe.
- Sits after the link that carries the muxed stream. A mux sequenced by a 2-bit slot counter drives it.

---
 rtl/tdm_demux1_to_4_pkg.sv | 17 +
 rtl/tdm_slot_counter.sv | 58 +++++
 rtl/tdm_demux1_to_4.sv | 111 +++++++++++
 tb/tb_tdm_demux1_to_4.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/tdm_demux1_to_4_pkg.sv
// Slot encoding shared by the TDM mux sequencer and the 1-to-4 demux.
// Provides the slot type, slot constants and the modulo-4 slot step.
package tdm_demux1_to_4_pkg;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_I0 = 2'b00;
    localparam slot_t SLOT_I1 = 2'b01;
    localparam slot_t SLOT_I2 = 2'b10;
    localparam slot_t SLOT_I3 = 2'b11;

    // 2-bit add wraps 11 -> 00 naturally
    function automatic slot_t slot_next(slot_t s);
        return s + 2'd1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot counter with frame lock and sync alignment for the TDM demux.
// Ports: clock, reset (sync, active-high), en, sync -> s1, s0, locked,
//        sync_err (registered pulse), wrap (comb: this en closes slot 3).
module tdm_slot_counter
    import tdm_demux1_to_4_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic sync,
    output logic s1,
    output logic s0,
    output logic locked,
    output logic sync_err,
    output logic wrap
);

    slot_t slot_q, slot_d;
    logic  locked_q, locked_d;
    logic  err_q, err_d;

    always_comb begin
        slot_d   = slot_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        wrap     = 1'b0;
        if (en) begin
            if (sync) begin
                // sync always (re)aligns: the sync sample is slot 0,
                // so the next expected slot is 1
                err_d    = locked_q && (slot_q != SLOT_I0);
                slot_d   = SLOT_I1;
                locked_d = 1'b1;
            end else if (locked_q) begin
                wrap   = (slot_q == SLOT_I3);
                slot_d = slot_next(slot_q);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q   <= SLOT_I0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign s1       = slot_q[1];
    assign s0       = slot_q[0];
    assign locked   = locked_q;
    assign sync_err = err_q;

endmodule

// File: rtl/tdm_demux1_to_4.sv
// 1-to-4 TDM demux: steers slot samples into staging regs and publishes
// a whole frame on out0..out3 with a one-cycle frame_valid pulse.
// Ports: clock, reset (sync, active-high), din[WIDTH], en, sync ->
//        out0..out3[WIDTH], frame_valid, s1, s0, locked, sync_err.
module tdm_demux1_to_4
    import tdm_demux1_to_4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             sync,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             frame_valid,
    output logic             s1,
    output logic             s0,
    output logic             locked,
    output logic             sync_err
);

    logic             wrap;
    slot_t            slot;
    logic [WIDTH-1:0] stage0_q, stage0_d;
    logic [WIDTH-1:0] stage1_q, stage1_d;
    logic [WIDTH-1:0] stage2_q, stage2_d;
    logic [WIDTH-1:0] out0_q, out0_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;
    logic [WIDTH-1:0] out3_q, out3_d;
    logic             fv_q, fv_d;

    tdm_slot_counter u_cnt (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .sync     (sync),
        .s1       (s1),
        .s0       (s0),
        .locked   (locked),
        .sync_err (sync_err),
        .wrap     (wrap)
    );

    assign slot = {s1, s0};

    always_comb begin
        stage0_d = stage0_q;
        stage1_d = stage1_q;
        stage2_d = stage2_q;
        out0_d   = out0_q;
        out1_d   = out1_q;
        out2_d   = out2_q;
        out3_d   = out3_q;
        fv_d     = 1'b0;
        if (en) begin
            if (sync) begin
                // sync sample is always slot 0; a misaligned partial
                // frame is simply abandoned and overwritten later
                stage0_d = din;
            end else if (locked) begin
                unique case (slot)
                    SLOT_I0: stage0_d = din;
                    SLOT_I1: stage1_d = din;
                    SLOT_I2: stage2_d = din;
                    SLOT_I3: ;
                endcase
            end
        end
        if (wrap) begin
            out0_d = stage0_q;
            out1_d = stage1_q;
            out2_d = stage2_q;
            out3_d = din;
            fv_d   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stage0_q <= '0;
            stage1_q <= '0;
            stage2_q <= '0;
            out0_q   <= '0;
            out1_q   <= '0;
            out2_q   <= '0;
            out3_q   <= '0;
            fv_q     <= 1'b0;
        end else begin
            stage0_q <= stage0_d;
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
            out0_q   <= out0_d;
            out1_q   <= out1_d;
            out2_q   <= out2_d;
            out3_q   <= out3_d;
            fv_q     <= fv_d;
        end
    end

    assign out0        = out0_q;
    assign out1        = out1_q;
    assign out2        = out2_q;
    assign out3        = out3_q;
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_tdm_demux1_to_4.sv
// Directed vector bench for tdm_demux1_to_4 (WIDTH=1).
// Each vector: inputs for one edge, expected outputs just after it.
module tb_tdm_demux1_to_4;

    logic clock = 1'b0;
    logic reset;
    logic din;
    logic en;
    logic sync;
    logic out0, out1, out2, out3;
    logic frame_valid, s1, s0, locked, sync_err;

    always #5 clock = ~clock;

    tdm_demux1_to_4 #(.WIDTH(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .din         (din),
        .en          (en),
        .sync        (sync),
        .out0        (out0),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .frame_valid (frame_valid),
        .s1          (s1),
        .s0          (s0),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       sync;
        logic       din;
        logic [3:0] outs;
        logic       fv;
        logic [1:0] slot;
        logic       lk;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    int   applied = 0;
    int   miscmp  = 0;

    function automatic vec_t v(logic r, logic e, logic s, logic d,
                               logic [3:0] o, logic f, logic [1:0] sl,
                               logic l, logic er);
        vec_t x;
        x.rst = r; x.en = e; x.sync = s; x.din = d;
        x.outs = o; x.fv = f; x.slot = sl; x.lk = l; x.err = er;
        return x;
    endfunction

    task automatic step(input vec_t x, input string tag);
        logic [8:0] act, exp;
        reset = x.rst; en = x.en; sync = x.sync; din = x.din;
        @(posedge clock);
        #1;
        act = {out0, out1, out2, out3, frame_valid, s1, s0, locked, sync_err};
        exp = {x.outs, x.fv, x.slot, x.lk, x.err};
        applied++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got o=%b fv=%b s=%b lk=%b err=%b, want o=%b fv=%b s=%b lk=%b err=%b",
                     tag, act[8:5], act[4], act[3:2], act[1], act[0],
                     exp[8:5], exp[4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; sync = 1'b0; din = 1'b0;

        // aligned frame 1,0,1,1
        vecs.push_back(v(1,0,0,0, 4'b0000,0,2'b00,0,0));
        vecs.push_back(v(0,1,1,1, 4'b0000,0,2'b01,1,0));
        vecs.push_back(v(0,1,0,0, 4'b0000,0,2'b10,1,0));
        vecs.push_back(v(0,1,0,1, 4'b0000,0,2'b11,1,0));
        vecs.push_back(v(0,1,0,1, 4'b1011,1,2'b00,1,0));
        vecs.push_back(v(0,0,0,0, 4'b1011,0,2'b00,1,0));
        // pre-lock data ignored, then sync locks
        vecs.push_back(v(1,0,0,0, 4'b0000,0,2'b00,0,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(0,1,0,1, 4'b0000,0,2'b00,0,0));
        vecs.push_back(v(0,1,1,0, 4'b0000,0,2'b01,1,0));
        // gapped strobes; gaps drive sync=1/din=1 which must be ignored
        vecs.push_back(v(1,0,0,0, 4'b0000,0,2'b00,0,0));
        vecs.push_back(v(0,1,1,1, 4'b0000,0,2'b01,1,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0,0,1,1, 4'b0000,0,2'b01,1,0));
        vecs.push_back(v(0,1,0,0, 4'b0000,0,2'b10,1,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0,0,1,1, 4'b0000,0,2'b10,1,0));
        vecs.push_back(v(0,1,0,1, 4'b0000,0,2'b11,1,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0,0,1,0, 4'b0000,0,2'b11,1,0));
        vecs.push_back(v(0,1,0,1, 4'b1011,1,2'b00,1,0));
        vecs.push_back(v(0,0,0,0, 4'b1011,0,2'b00,1,0));
        // misaligned sync at slot 10, then 0,1,1,0 realigned
        vecs.push_back(v(0,1,1,0, 4'b1011,0,2'b01,1,0));
        vecs.push_back(v(0,1,0,1, 4'b1011,0,2'b10,1,0));
        vecs.push_back(v(0,1,1,0, 4'b1011,0,2'b01,1,1));
        vecs.push_back(v(0,0,0,0, 4'b1011,0,2'b01,1,0));
        vecs.push_back(v(0,1,0,1, 4'b1011,0,2'b10,1,0));
        vecs.push_back(v(0,1,0,1, 4'b1011,0,2'b11,1,0));
        vecs.push_back(v(0,1,0,0, 4'b0110,1,2'b00,1,0));
        // back-to-back frames 1000 then 0001
        vecs.push_back(v(0,1,1,1, 4'b0110,0,2'b01,1,0));
        vecs.push_back(v(0,1,0,0, 4'b0110,0,2'b10,1,0));
        vecs.push_back(v(0,1,0,0, 4'b0110,0,2'b11,1,0));
        vecs.push_back(v(0,1,0,0, 4'b1000,1,2'b00,1,0));
        vecs.push_back(v(0,1,1,0, 4'b1000,0,2'b01,1,0));
        vecs.push_back(v(0,1,0,0, 4'b1000,0,2'b10,1,0));
        vecs.push_back(v(0,1,0,0, 4'b1000,0,2'b11,1,0));
        vecs.push_back(v(0,1,0,1, 4'b0001,1,2'b00,1,0));
        // reset mid-frame, reset wins over en; no frame without sync
        vecs.push_back(v(0,1,1,1, 4'b0001,0,2'b01,1,0));
        vecs.push_back(v(0,1,0,1, 4'b0001,0,2'b10,1,0));
        vecs.push_back(v(1,1,0,1, 4'b0000,0,2'b00,0,0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(0,1,0,1, 4'b0000,0,2'b00,0,0));

        foreach (vecs[i])
            step(vecs[i], $sformatf("vec%0d", i));

        // hand sequence: misaligned sync landing on slot 11 must not
        // publish a frame even though that slot would normally wrap
        step(v(0,1,1,1, 4'b0000,0,2'b01,1,0), "seq_a0");
        step(v(0,1,0,1, 4'b0000,0,2'b10,1,0), "seq_a1");
        step(v(0,1,0,1, 4'b0000,0,2'b11,1,0), "seq_a2");
        step(v(0,1,1,0, 4'b0000,0,2'b01,1,1), "seq_a3_err");
        step(v(0,1,0,1, 4'b0000,0,2'b10,1,0), "seq_a4");
        step(v(0,1,0,0, 4'b0000,0,2'b11,1,0), "seq_a5");
        step(v(0,1,0,1, 4'b0101,1,2'b00,1,0), "seq_a6_frame");
        // sync at slot 00 while locked is a clean realign, no error
        step(v(0,1,1,1, 4'b0101,0,2'b01,1,0), "seq_b0_nerr");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
        $finish;
    end

endmodule
